// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and widths for the async SRAM scheduler
package sram_pkg;

  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {
    REQ_DRAM = 2'd0,
    REQ_SPI  = 2'd1,
    REQ_AUX  = 2'd2
  } req_id_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_WHOLD   = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

endpackage

// File: rtl/sram_grant_logic.sv
// rtl/sram_grant_logic.sv - fixed-priority requester pick with AUX anti-starvation counter
module sram_grant_logic
  import sram_pkg::*;
#(
  parameter int AUX_MAX_WAIT = 3,
  localparam int WAIT_W = $clog2(AUX_MAX_WAIT + 1)
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_dram_req,
  input  logic       i_spi_req,
  input  logic       i_aux_req,
  input  logic       i_grant_en,
  output logic       o_grant_valid,
  output logic [1:0] o_grant_id
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(AUX_MAX_WAIT);

  logic [WAIT_W-1:0] r_aux_wait;
  logic              w_valid;
  req_id_t           w_id;

  always_comb begin
    w_valid = 1'b0;
    w_id    = REQ_DRAM;
    if (i_dram_req) begin
      w_valid = 1'b1;
      w_id    = REQ_DRAM;
    end else if (i_aux_req && (r_aux_wait >= WAIT_MAX)) begin
      w_valid = 1'b1;
      w_id    = REQ_AUX;
    end else if (i_spi_req) begin
      w_valid = 1'b1;
      w_id    = REQ_SPI;
    end else if (i_aux_req) begin
      w_valid = 1'b1;
      w_id    = REQ_AUX;
    end
  end

  // Counts SPI wins taken while AUX was waiting; DRAM wins do not age AUX.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_aux_wait <= '0;
    end else if (!i_aux_req) begin
      r_aux_wait <= '0;
    end else if (i_grant_en && w_valid) begin
      if (w_id == REQ_AUX) begin
        r_aux_wait <= '0;
      end else if ((w_id == REQ_SPI) && (r_aux_wait != WAIT_MAX)) begin
        r_aux_wait <= r_aux_wait + 1'b1;
      end
    end
  end

  assign o_grant_valid = w_valid;
  assign o_grant_id    = w_id;

endmodule

// File: rtl/sram_scheduler.sv
// rtl/sram_scheduler.sv - three-requester scheduler and strobe sequencer for a 512Kx16 async SRAM
module sram_scheduler
  import sram_pkg::*;
#(
  parameter int RD_CYCLES    = 4,
  parameter int WR_CYCLES    = 4,
  parameter int AUX_MAX_WAIT = 3
) (
  input  logic                i_clk200,
  input  logic                i_reset,
  input  logic                i_dram_req,
  output logic                o_dram_ack,
  input  logic                i_dram_read,
  input  logic [SRAM_AW-1:0]  i_dram_address,
  input  logic                i_dram_lb,
  input  logic                i_dram_ub,
  input  logic [SRAM_DW-1:0]  i_dram_out_sram_in,
  output logic [SRAM_DW-1:0]  o_dram_in_sram_out,
  input  logic                i_spi_req,
  output logic                o_spi_ack,
  input  logic                i_spi_read,
  input  logic [SRAM_AW-1:0]  i_spi_address,
  input  logic                i_spi_ub,
  input  logic [7:0]          i_spi_out_sram_in,
  output logic [SRAM_DW-1:0]  o_spi_in_sram_out,
  input  logic                i_aux_req,
  output logic                o_aux_ack,
  input  logic                i_aux_read,
  input  logic [SRAM_AW-1:0]  i_aux_address,
  input  logic                i_aux_lb,
  input  logic                i_aux_ub,
  input  logic [SRAM_DW-1:0]  i_aux_out_sram_in,
  output logic [SRAM_DW-1:0]  o_aux_in_sram_out,
  output logic                o_sr_oe_n,
  output logic                o_sr_we_n,
  output logic                o_sr_lb_n,
  output logic                o_sr_ub_n,
  output logic [SRAM_AW-1:0]  o_sr_a,
  inout  wire  [SRAM_DW-1:0]  io_sr_d
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

  logic               w_grant_valid;
  logic [1:0]         w_grant_id;
  logic               w_grant_en;

  state_t             r_state;
  state_t             w_state_next;
  req_id_t            r_id;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_oe_n;
  logic               r_we_n;
  logic               r_lb_n;
  logic               r_ub_n;
  logic [SRAM_AW-1:0] r_sr_a;
  logic [SRAM_DW-1:0] r_dout;
  logic               r_sr_d_oe;

  logic               r_dram_ack;
  logic               r_spi_ack;
  logic               r_aux_ack;
  logic [SRAM_DW-1:0] r_dram_rd;
  logic [SRAM_DW-1:0] r_spi_rd;
  logic [SRAM_DW-1:0] r_aux_rd;

  logic               w_sel_read;
  logic [SRAM_AW-1:0] w_sel_addr;
  logic               w_sel_lb_n;
  logic               w_sel_ub_n;
  logic [SRAM_DW-1:0] w_sel_data;

  assign w_grant_en = (r_state == ST_IDLE);

  sram_grant_logic #(
    .AUX_MAX_WAIT (AUX_MAX_WAIT)
  ) u_grant (
    .i_clk         (i_clk200),
    .i_reset       (i_reset),
    .i_dram_req    (i_dram_req),
    .i_spi_req     (i_spi_req),
    .i_aux_req     (i_aux_req),
    .i_grant_en    (w_grant_en),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  // SPI is byte-wide: one lane on writes, the whole word on reads.
  always_comb begin
    w_sel_read = 1'b1;
    w_sel_addr = '0;
    w_sel_lb_n = 1'b1;
    w_sel_ub_n = 1'b1;
    w_sel_data = '0;
    case (w_grant_id)
      REQ_DRAM: begin
        w_sel_read = i_dram_read;
        w_sel_addr = i_dram_address;
        w_sel_lb_n = !i_dram_lb;
        w_sel_ub_n = !i_dram_ub;
        w_sel_data = i_dram_out_sram_in;
      end
      REQ_SPI: begin
        w_sel_read = i_spi_read;
        w_sel_addr = i_spi_address;
        w_sel_lb_n = i_spi_read ? 1'b0 : i_spi_ub;
        w_sel_ub_n = i_spi_read ? 1'b0 : !i_spi_ub;
        w_sel_data = {i_spi_out_sram_in, i_spi_out_sram_in};
      end
      REQ_AUX: begin
        w_sel_read = i_aux_read;
        w_sel_addr = i_aux_address;
        w_sel_lb_n = !i_aux_lb;
        w_sel_ub_n = !i_aux_ub;
        w_sel_data = i_aux_out_sram_in;
      end
      default: begin
        w_sel_read = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk200) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_state_next = w_sel_read ? ST_READ : ST_WRITE;
        end
      end
      ST_READ: begin
        if (r_cnt == RD_LAST) begin
          w_state_next = ST_RECOVER;
        end
      end
      ST_WRITE: begin
        if (r_cnt == WR_LAST) begin
          w_state_next = ST_WHOLD;
        end
      end
      ST_WHOLD:   w_state_next = ST_RECOVER;
      ST_RECOVER: w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk200) begin
    if (i_reset) begin
      r_id       <= REQ_DRAM;
      r_cnt      <= '0;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_lb_n     <= 1'b1;
      r_ub_n     <= 1'b1;
      r_sr_a     <= '0;
      r_dout     <= '0;
      r_sr_d_oe  <= 1'b0;
      r_dram_ack <= 1'b0;
      r_spi_ack  <= 1'b0;
      r_aux_ack  <= 1'b0;
      r_dram_rd  <= '0;
      r_spi_rd   <= '0;
      r_aux_rd   <= '0;
    end else begin
      r_dram_ack <= 1'b0;
      r_spi_ack  <= 1'b0;
      r_aux_ack  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_id   <= req_id_t'(w_grant_id);
            r_cnt  <= '0;
            r_sr_a <= w_sel_addr;
            r_dout <= w_sel_data;
            r_lb_n <= w_sel_lb_n;
            r_ub_n <= w_sel_ub_n;
            if (w_sel_read) begin
              r_oe_n <= 1'b0;
            end else begin
              r_we_n    <= 1'b0;
              r_sr_d_oe <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (r_cnt == RD_LAST) begin
            r_oe_n <= 1'b1;
            r_lb_n <= 1'b1;
            r_ub_n <= 1'b1;
            // Ack is registered here so it lands in RECOVER with the data.
            case (r_id)
              REQ_DRAM: begin r_dram_rd <= io_sr_d; r_dram_ack <= 1'b1; end
              REQ_SPI:  begin r_spi_rd  <= io_sr_d; r_spi_ack  <= 1'b1; end
              REQ_AUX:  begin r_aux_rd  <= io_sr_d; r_aux_ack  <= 1'b1; end
              default:  r_dram_ack <= 1'b0;
            endcase
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          if (r_cnt == WR_LAST) begin
            r_we_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_WHOLD: begin
          r_sr_d_oe <= 1'b0;
          r_lb_n    <= 1'b1;
          r_ub_n    <= 1'b1;
          case (r_id)
            REQ_DRAM: r_dram_ack <= 1'b1;
            REQ_SPI:  r_spi_ack  <= 1'b1;
            REQ_AUX:  r_aux_ack  <= 1'b1;
            default:  r_dram_ack <= 1'b0;
          endcase
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign io_sr_d = r_sr_d_oe ? r_dout : {SRAM_DW{1'bz}};

  assign o_sr_oe_n          = r_oe_n;
  assign o_sr_we_n          = r_we_n;
  assign o_sr_lb_n          = r_lb_n;
  assign o_sr_ub_n          = r_ub_n;
  assign o_sr_a             = r_sr_a;
  assign o_dram_ack         = r_dram_ack;
  assign o_spi_ack          = r_spi_ack;
  assign o_aux_ack          = r_aux_ack;
  assign o_dram_in_sram_out = r_dram_rd;
  assign o_spi_in_sram_out  = r_spi_rd;
  assign o_aux_in_sram_out  = r_aux_rd;

endmodule

// File: doc/sram_scheduler.md
Name: sram_scheduler

Overview:
Three-requester scheduler for the shared 512Kx16 async SRAM in the clk200 domain. Requesters are the DRAM port (Amiga chip-RAM emulation, latency-critical), the SPI controller (RPi access) and a new AUX port reserved for a future DMA/blitter-assist engine. It sequences SR_* strobes with parameterised access timing. Priority is fixed: DRAM first, then SPI and AUX, with an AUX anti-starvation boost.

Parameters:
RD_CYCLES, 4, clk200 cycles SR_OE_n held low per read (min 2)
WR_CYCLES, 4, clk200 cycles SR_WE_n held low per write (min 2)
AUX_MAX_WAIT, 3, consecutive SPI grants while AUX pending before AUX outranks SPI (min 1)

Ports:
clk200  in  1  sole clock
reset  in  1  synchronous, active-high
dram_req  in  1  level request, held until ack
dram_ack  out  1  one-cycle completion pulse
dram_read  in  1  1=read 0=write
dram_address  in  19  word address
dram_lb / dram_ub  in  1 each  byte enables, active-high
dram_out_sram_in  in  16  write data
dram_in_sram_out  out  16  read data, valid while dram_ack=1 and held until next DRAM read
spi_req, spi_ack, spi_read, spi_address[18:0]  as DRAM port
spi_ub  in  1  1=upper byte, 0=lower byte
spi_out_sram_in  in  8  write byte, replicated onto both SR_D halves
spi_in_sram_out  out  16  full word read data
aux_req, aux_ack, aux_read, aux_address[18:0], aux_lb, aux_ub, aux_out_sram_in[15:0], aux_in_sram_out[15:0]  as DRAM port
SR_OE_n, SR_WE_n, SR_LB_n, SR_UB_n  out  1 each  SRAM strobes, active-low, registered
SR_A  out  19  SRAM address, registered
SR_D  inout  16  SRAM data, driven only in WRITE and WHOLD

Behaviour:
- Reset values: all strobes 1, SR_A=0, SR_D released (Z), all acks 0, read-data registers 0, state IDLE, aux_wait=0.
- States: IDLE, READ, WRITE, WHOLD, RECOVER.
- IDLE: pick a winner among asserted reqs. DRAM wins always. Otherwise AUX wins if aux_wait>=AUX_MAX_WAIT, else SPI wins, else AUX. On a grant, latch the requester id, address, lanes and data. Next cycle SR_A is valid and the OE_n or WE_n/LB_n/UB_n strobes are low.
- SPI lanes: SR_UB_n = !spi_ub, SR_LB_n = spi_ub. On reads both lanes are enabled.
- READ: hold for RD_CYCLES. SR_D is sampled into the winner's read register on the last READ cycle, then go to RECOVER with OE_n=1.
- WRITE: hold for WR_CYCLES with WE_n low and data driven, then WHOLD.
- WHOLD: 1 cycle with WE_n=1 and data still driven (hold time), then RECOVER with SR_D released.
- RECOVER: 1 cycle with strobes high and the winner's ack=1, then IDLE. Only one ack is high in any cycle.
- Requester contract: drop req on the edge where ack=1 is sampled. The mandatory IDLE cycle guarantees a dropped req is never re-granted.
- Access cost: read = RD_CYCLES+2 cycles from grant edge to IDLE; write = WR_CYCLES+3 cycles.
- aux_wait: +1 (saturating at AUX_MAX_WAIT) on each SPI grant while aux_req=1. Cleared on an AUX grant or whenever aux_req=0. DRAM grants leave it unchanged.
- Changes to req, address or data after a grant are ignored until ack.
- A req deasserted before grant is simply not served; no error.
- Reset mid-access: next edge forces the reset state, strobes rise, SR_D is released and no ack is issued. Pending reqs are re-arbitrated from IDLE.
- Byte enables lb=ub=0 on a DRAM/AUX write: the cycle still runs with both lanes disabled, and ack is issued.

Decomposition:
- Shared package sram_pkg: requester id enum (REQ_DRAM, REQ_SPI, REQ_AUX), state enum, SRAM_AW=19, SRAM_DW=16.
- One natural sub-module, sram_grant_logic: combinational priority plus the aux_wait counter, so it can be unit-tested alone.
- The strobe sequencer stays in the parent.

Test Plan:
- DRAM read at 0x12345, SRAM model holds 0xBEEF -> OE_n low exactly 4 cycles; dram_ack single pulse with dram_in_sram_out=0xBEEF at grant+5; SR_D never driven.
- SPI write 0xA5 to 0x00010 with spi_ub=1 -> SR_UB_n=0, SR_LB_n=1, SR_D=0xA5A5, WE_n low 4 cycles, data held 1 cycle after WE_n rises; model upper byte becomes 0xA5.
- DRAM, SPI and AUX asserted in the same cycle -> grant order DRAM, SPI, AUX; acks never overlap; each ack followed by at least one IDLE cycle.
- SPI requesting back-to-back with AUX held -> AUX granted after exactly 3 SPI grants. A DRAM req injected meanwhile still preempts AUX at the next IDLE.
- Reset asserted in cycle 2 of a WRITE -> next cycle WE_n=1, SR_D=Z, no ack. With req still high after reset, the access re-executes and acks once.
- Requester holds req one cycle past ack (contract violation check): assertion fires; the normal path shows exactly one access per request.
